// File: rtl/nand_corr_stream_if.sv
// Handshake bundle for nand_corr_stream: frame load, error-vector beats and
// corrected output beats with frame flags and per-frame correction count.
interface nand_corr_stream_if #(
  parameter int DATA_BITS = 4348,
  parameter int BITS      = 8
);
  localparam int CW = $clog2(DATA_BITS + 1);

  logic                 load_in;
  logic                 load_ready;
  logic [DATA_BITS-1:0] b_in;
  logic                 corr_en;
  logic [BITS-1:0]      err_in;
  logic                 err_valid;
  logic                 err_ready;
  logic [BITS-1:0]      b_out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 first_out;
  logic                 last_out;
  logic [CW-1:0]        corr_cnt;
  logic                 corr_cnt_valid;

  modport master (
    output load_in, b_in, corr_en, err_in, err_valid, out_ready,
    input  load_ready, err_ready, b_out, out_valid, first_out, last_out,
           corr_cnt, corr_cnt_valid
  );

  modport slave (
    input  load_in, b_in, corr_en, err_in, err_valid, out_ready,
    output load_ready, err_ready, b_out, out_valid, first_out, last_out,
           corr_cnt, corr_cnt_valid
  );
endinterface

// File: rtl/nand_corr_stream.sv
// Ping-pong codeword buffer that streams frames MSB-first in BITS-wide beats,
// optionally XORing an error-vector stream in and counting flipped bits.
module nand_corr_stream #(
  parameter int DATA_BITS = 4348,
  parameter int BITS      = 8
) (
  input logic          clk_in,
  input logic          rst_in,
  nand_corr_stream_if.slave bus
);
  localparam int BEATS = (DATA_BITS + BITS - 1) / BITS;
  localparam int PAD   = BEATS * BITS - DATA_BITS;
  localparam int PW    = BEATS * BITS;
  localparam int CW    = $clog2(DATA_BITS + 1);
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = (PW > 1) ? $clog2(PW) : 1;
  localparam int PCW   = $clog2(BITS + 1);
  localparam logic [BITS-1:0] LAST_MASK = {BITS{1'b1}} << PAD;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t               state, state_nxt;
  logic [1:0]           full, full_nxt;
  logic [DATA_BITS-1:0] slot_data [2];
  logic [1:0]           slot_corr;
  logic                 wr_ptr, rd_ptr;
  logic                 load_ready_r;
  logic                 accept;
  logic [BCW-1:0]       beat;
  logic                 last_beat;
  logic [CW-1:0]        acc, acc_sum, cnt_r;
  logic                 cnt_vld;
  logic [PW-1:0]        padded;
  logic [IW-1:0]        beat_lsb;
  logic [BITS-1:0]      data_beat, vmask, err_m, b_out;
  logic                 cur_corr, out_valid, xfer, last_xfer, err_ready;
  logic                 first_out, last_out;

  function automatic logic [PCW-1:0] popcnt(input logic [BITS-1:0] v);
    logic [PCW-1:0] s;
    s = '0;
    for (int i = 0; i < BITS; i++) s = s + PCW'(v[i]);
    return s;
  endfunction

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                            input logic [PCW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + (CW+1)'(b);
    return s[CW] ? {CW{1'b1}} : s[CW-1:0];
  endfunction

  assign accept = bus.load_in && load_ready_r;

  // Beat selection: codeword left-aligned in a beat-multiple vector, pad bits zero
  always_comb begin
    padded = '0;
    padded[PW-1 -: DATA_BITS] = slot_data[rd_ptr];
    beat_lsb  = IW'((BEATS - 1 - int'(beat)) * BITS);
    data_beat = padded[beat_lsb +: BITS];
    last_beat = (beat == BCW'(BEATS - 1));
    vmask     = last_beat ? LAST_MASK : {BITS{1'b1}};
  end

  always_comb begin
    cur_corr  = slot_corr[rd_ptr];
    out_valid = (state == S_STREAM) && (cur_corr ? bus.err_valid : 1'b1);
    xfer      = out_valid && bus.out_ready;
    last_xfer = xfer && last_beat;
    err_ready = cur_corr && xfer;
    err_m     = cur_corr ? (bus.err_in & vmask) : '0;
    b_out     = out_valid ? (data_beat ^ err_m) : '0;
    first_out = out_valid && (beat == '0);
    last_out  = out_valid && last_beat;
  end

  assign acc_sum = sat_add(acc, popcnt(err_m));

  always_comb begin
    full_nxt = full;
    if (last_xfer) full_nxt[rd_ptr] = 1'b0;
    if (accept)    full_nxt[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (full[rd_ptr]) state_nxt = S_STREAM;
      S_STREAM: if (last_xfer && !full[~rd_ptr]) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Slot bookkeeping, beat counter and correction accumulator
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      full         <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      load_ready_r <= 1'b1;
      beat         <= '0;
      acc          <= '0;
      cnt_r        <= '0;
      cnt_vld      <= 1'b0;
    end else begin
      full         <= full_nxt;
      wr_ptr       <= wr_ptr ^ accept;
      load_ready_r <= !full_nxt[wr_ptr ^ accept];
      cnt_vld      <= last_xfer;
      if (last_xfer) begin
        rd_ptr <= ~rd_ptr;
        beat   <= '0;
        acc    <= '0;
        cnt_r  <= cur_corr ? acc_sum : '0;
      end else if (xfer) begin
        beat <= beat + BCW'(1);
        acc  <= acc_sum;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (accept) begin
      slot_data[wr_ptr] <= bus.b_in;
      slot_corr[wr_ptr] <= bus.corr_en;
    end
  end

  assign bus.load_ready     = load_ready_r;
  assign bus.out_valid      = out_valid;
  assign bus.err_ready      = err_ready;
  assign bus.b_out          = b_out;
  assign bus.first_out      = first_out;
  assign bus.last_out       = last_out;
  assign bus.corr_cnt       = cnt_r;
  assign bus.corr_cnt_valid = cnt_vld;
endmodule

// File: tb/tb_nand_corr_stream.sv
// Directed bench for nand_corr_stream: table of single-frame scenarios plus
// hand-written latency, back-to-back and mid-frame reset sequences.
module tb_nand_corr_stream;
  localparam int DATA_BITS = 4348;
  localparam int BITS      = 8;
  localparam int BEATS     = 544;
  localparam int CW        = 13;

  typedef struct packed {
    bit        corr;
    bit        rnd;
    int        eb0;
    logic [7:0] ev0;
    int        eb1;
    logic [7:0] ev1;
    int        eb2;
    logic [7:0] ev2;
    int        probe;
    logic [7:0] pexp;
    int        ecnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nand_corr_stream_if #(.DATA_BITS(DATA_BITS), .BITS(BITS)) bus ();
  nand_corr_stream #(.DATA_BITS(DATA_BITS), .BITS(BITS)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_BITS-1:0] frame;
  bit          cfg_corr, cfg_rnd;
  int          cfg_eb [3];
  logic [7:0]  cfg_ev [3];
  vec_t        tbl [6];

  bit          mon_on;
  int          tb_beat, frames_done, bad_beats, first_bad, flag_bad, stall_bad, pulses;
  logic [CW-1:0] last_cnt;
  logic [7:0]  got [BEATS];
  int          first_cyc [4];
  int          last_cyc [4];
  bit          mon_xf, prev_stall, prev_first, prev_last;
  logic [7:0]  prev_b;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] base_beat(input int k);
    logic [63:0] t;
    t = 64'hD32B9F9F247354C0;
    if (k < 512) return 8'hFF;
    if (k < 536) return 8'h00;
    return t[(543 - k) * 8 +: 8];
  endfunction

  function automatic logic [7:0] err_of(input int k);
    for (int j = 0; j < 3; j++) if (cfg_eb[j] == k) return cfg_ev[j];
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_beat(input int k);
    logic [7:0] m;
    m = (k == BEATS - 1) ? 8'hF0 : 8'hFF;
    return base_beat(k) ^ (cfg_corr ? (err_of(k) & m) : 8'h00);
  endfunction

  // Sink / error-source model: drive on the falling edge, sample 1ns later
  always begin
    @(negedge clk);
    bus.err_in    = err_of(tb_beat);
    bus.out_ready = (cfg_rnd && mon_on) ? ($urandom_range(0, 3) != 0) : 1'b1;
    bus.err_valid = (cfg_rnd && mon_on) ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    if (bus.corr_cnt_valid) begin
      pulses++;
      last_cnt = bus.corr_cnt;
    end
    if (mon_on) begin
      mon_xf = bus.out_valid && bus.out_ready;
      if (bus.err_ready !== (cfg_corr && mon_xf)) flag_bad++;
      if (prev_stall && bus.out_valid &&
          (bus.b_out !== prev_b || bus.first_out !== prev_first || bus.last_out !== prev_last))
        stall_bad++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_b     = bus.b_out;
      prev_first = bus.first_out;
      prev_last  = bus.last_out;
      if (mon_xf) begin
        if (bus.first_out !== (tb_beat == 0) || bus.last_out !== (tb_beat == BEATS - 1))
          flag_bad++;
        if (bus.b_out !== exp_beat(tb_beat)) begin
          if (bad_beats == 0) first_bad = tb_beat;
          bad_beats++;
        end
        got[tb_beat] = bus.b_out;
        if (tb_beat == 0 && frames_done < 4) first_cyc[frames_done] = cyc;
        if (tb_beat == BEATS - 1) begin
          if (frames_done < 4) last_cyc[frames_done] = cyc;
          frames_done++;
          tb_beat = 0;
        end else begin
          tb_beat++;
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_stats();
    tb_beat = 0; frames_done = 0; bad_beats = 0; first_bad = -1;
    flag_bad = 0; stall_bad = 0; pulses = 0; prev_stall = 1'b0;
  endtask

  task automatic set_cfg(input vec_t v);
    cfg_corr = v.corr; cfg_rnd = v.rnd;
    cfg_eb[0] = v.eb0; cfg_ev[0] = v.ev0;
    cfg_eb[1] = v.eb1; cfg_ev[1] = v.ev1;
    cfg_eb[2] = v.eb2; cfg_ev[2] = v.ev2;
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge
  task automatic do_load(input bit corr, output int acc_cyc, output int waited);
    bus.b_in = frame; bus.corr_en = corr; bus.load_in = 1'b1; waited = 0;
    #1;
    while (!bus.load_ready && waited < 5000) begin
      @(negedge clk); #1; waited++;
    end
    acc_cyc = cyc;
    chk("load_accepted", waited < 5000, 1);
    @(negedge clk);
    bus.load_in = 1'b0;
  endtask

  task automatic check_latency();
    #1;
    chk("lat_idle_valid", bus.out_valid, 0);
    chk("lat_load_ready", bus.load_ready, 1);
    @(negedge clk); #1;
    chk("lat_out_valid", bus.out_valid, 1);
    chk("lat_first_out", bus.first_out, 1);
  endtask

  task automatic wait_frames(input int target, input int exp_pulses, input int exp_cnt);
    int n;
    n = 0;
    while (frames_done < target && n < 20000) begin @(negedge clk); n++; end
    chk("frames_done", frames_done, target);
    repeat (3) @(negedge clk);
    #1;
    chk("beats_bad", bad_beats, 0);
    if (bad_beats != 0) $display("  first bad beat %0d", first_bad);
    chk("flags_bad", flag_bad, 0);
    chk("stall_unstable", stall_bad, 0);
    chk("cnt_pulses", pulses, exp_pulses);
    chk("corr_cnt", last_cnt, exp_cnt);
    chk("idle_after", bus.out_valid, 0);
  endtask

  int a0, a1, a2, w0, w1, w2;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.load_in = 1'b0; bus.b_in = '0; bus.corr_en = 1'b0;
    bus.err_in = '0; bus.err_valid = 1'b0; bus.out_ready = 1'b1;
    mon_on = 1'b0; cfg_corr = 1'b0; cfg_rnd = 1'b0;
    for (int j = 0; j < 3; j++) begin cfg_eb[j] = -1; cfg_ev[j] = 8'h00; end
    last_cnt = '0;
    clear_stats();
    frame = '0;
    frame[4347:252] = '1;
    frame[59:0] = 60'hD32B9F9F247354C;

    //          corr rnd  eb0  ev0    eb1  ev1    eb2  ev2    probe pexp  cnt
    tbl[0] = '{1'b0, 1'b0, -1, 8'h00,  -1, 8'h00,  -1, 8'h00, 543, 8'hC0, 0};
    tbl[1] = '{1'b1, 1'b0, 504, 8'h24, 293, 8'h10, 168, 8'h10, 504, 8'hDB, 4};
    tbl[2] = '{1'b1, 1'b0, 543, 8'hFF,  -1, 8'h00,  -1, 8'h00, 543, 8'h30, 4};
    tbl[3] = '{1'b1, 1'b1, 504, 8'h24, 293, 8'h10, 168, 8'h10, 168, 8'hEF, 4};
    tbl[4] = '{1'b0, 1'b0, 100, 8'hFF,  -1, 8'h00,  -1, 8'h00, 100, 8'hFF, 0};
    tbl[5] = '{1'b1, 1'b0, 520, 8'h81, 536, 8'hFF,  -1, 8'h00, 536, 8'h2C, 10};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_load_ready", bus.load_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_err_ready", bus.err_ready, 0);
    chk("rst_first_last", {bus.first_out, bus.last_out}, 0);
    chk("rst_b_out", bus.b_out, 0);
    chk("rst_corr_cnt", bus.corr_cnt, 0);
    chk("rst_cnt_valid", bus.corr_cnt_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      set_cfg(tbl[i]);
      clear_stats();
      @(negedge clk);
      mon_on = 1'b1;
      do_load(tbl[i].corr, a0, w0);
      if (!tbl[i].rnd) check_latency();
      wait_frames(1, 1, tbl[i].ecnt);
      chk($sformatf("probe_v%0d_beat%0d", i, tbl[i].probe), got[tbl[i].probe], tbl[i].pexp);
      mon_on = 1'b0;
    end

    // Three loads back to back: third waits for the first frame to drain
    set_cfg(tbl[0]);
    clear_stats();
    @(negedge clk);
    mon_on = 1'b1;
    do_load(1'b0, a0, w0);
    do_load(1'b0, a1, w1);
    #1;
    chk("b2b_load_ready_low", bus.load_ready, 0);
    do_load(1'b0, a2, w2);
    chk("b2b_third_waited", w2 > 100, 1);
    chk("b2b_third_after_last", (a2 > last_cyc[0]) && (a2 <= last_cyc[0] + 2), 1);
    wait_frames(3, 3, 0);
    chk("b2b_gap_1_2", first_cyc[1] - last_cyc[0], 1);
    chk("b2b_gap_2_3", first_cyc[2] - last_cyc[1], 1);
    mon_on = 1'b0;

    // Reset in the middle of a frame, then a clean corrected frame
    set_cfg(tbl[0]);
    clear_stats();
    @(negedge clk);
    mon_on = 1'b1;
    do_load(1'b0, a0, w0);
    w0 = 0;
    while (tb_beat < 200 && w0 < 5000) begin @(negedge clk); w0++; end
    chk("mid_reached_beat200", tb_beat >= 200, 1);
    #2;
    mon_on = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_load_ready", bus.load_ready, 1);
    chk("mid_rst_b_out", bus.b_out, 0);
    chk("mid_rst_corr_cnt", bus.corr_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("mid_rst_no_pulse", pulses, 0);
    chk("mid_rst_idle", bus.out_valid, 0);
    set_cfg(tbl[1]);
    clear_stats();
    @(negedge clk);
    mon_on = 1'b1;
    do_load(1'b1, a0, w0);
    check_latency();
    wait_frames(1, 1, 4);
    chk("post_rst_beat504", got[504], 8'hDB);
    mon_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
